// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around the cacheline arbiter.
// slave is the arbiter's view; master is the caches/memory view.
interface cacheline_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic              i_write;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    logic [1:0]        grant;
    logic              timeout_err;

    modport slave (
        input  i_addr, i_read, i_write, i_wdata,
        output i_rdata, i_resp,
        input  d_addr, d_read, d_write, d_wdata,
        output d_rdata, d_resp,
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_resp,
        output grant, timeout_err
    );

    modport master (
        output i_addr, i_read, i_write, i_wdata,
        input  i_rdata, i_resp,
        output d_addr, d_read, d_write, d_wdata,
        input  d_rdata, d_resp,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_resp,
        input  grant, timeout_err
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and D-cache.
// One outstanding transaction at a time; an IDLE cycle always follows each completion.
module cacheline_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINE_W         = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    cacheline_arbiter_if.slave io_bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]        r_state;
    logic              r_last;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [1:0]        r_grant;
    logic [CNT_W-1:0]  r_wd_cnt;
    logic              r_timeout;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_pick_d;
    logic              w_i_resp;
    logic              w_d_resp;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_win_read;
    logic              w_win_write;
    logic [LINE_W-1:0] w_win_wdata;

    always_comb begin
        w_req_i     = io_bus.i_read | io_bus.i_write;
        w_req_d     = io_bus.d_read | io_bus.d_write;
        // r_last is 1 when D won last; a tie goes to whoever did not win last
        w_pick_d    = w_req_d & (~w_req_i | ~r_last);
        w_win_addr  = w_pick_d ? io_bus.d_addr  : io_bus.i_addr;
        w_win_read  = w_pick_d ? io_bus.d_read  : io_bus.i_read;
        w_win_write = w_pick_d ? io_bus.d_write : io_bus.i_write;
        w_win_wdata = w_pick_d ? io_bus.d_wdata : io_bus.i_wdata;
        w_i_resp    = (r_state == ST_SERVE_I) & io_bus.mem_resp;
        w_d_resp    = (r_state == ST_SERVE_D) & io_bus.mem_resp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
            r_grant     <= 2'b00;
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_i | w_req_d) begin
                        r_state     <= w_pick_d ? ST_SERVE_D : ST_SERVE_I;
                        r_grant     <= w_pick_d ? 2'b10 : 2'b01;
                        r_last      <= w_pick_d;
                        r_mem_addr  <= w_win_addr;
                        r_mem_read  <= w_win_read;
                        r_mem_write <= w_win_write;
                        r_mem_wdata <= w_win_wdata;
                        r_wd_cnt    <= '0;
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if (io_bus.mem_resp) begin
                        r_state     <= ST_IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_grant     <= 2'b00;
                    end else if (r_wd_cnt != CNT_MAX) begin
                        // CNT_MAX of 0 never increments, which disables the watchdog
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                        if (r_wd_cnt + CNT_W'(1) == CNT_MAX) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.mem_addr    = r_mem_addr;
    assign io_bus.mem_read    = r_mem_read;
    assign io_bus.mem_write   = r_mem_write;
    assign io_bus.mem_wdata   = r_mem_wdata;
    assign io_bus.grant       = r_grant;
    assign io_bus.timeout_err = r_timeout;
    assign io_bus.i_resp      = w_i_resp;
    assign io_bus.d_resp      = w_d_resp;
    assign io_bus.i_rdata     = w_i_resp ? io_bus.mem_rdata : '0;
    assign io_bus.d_rdata     = w_d_resp ? io_bus.mem_rdata : '0;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: cache agents and a memory responder drive the
// interface; one monitor checks memory requests and responses against queued expectations.
module tb_cacheline_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned TO     = 8;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [255:0] wdata;
        bit          perturb;
    } cmd_t;

    typedef struct {
        logic [1:0]   grant;
        logic [31:0]  addr;
        logic         rd;
        logic         wr;
        logic [255:0] wdata;
        int           lat;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cacheline_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cacheline_arbiter #(
        .ADDR_W        (ADDR_W),
        .LINE_W        (LINE_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_t         i_q[$];
    cmd_t         d_q[$];
    logic [255:0] i_exp[$];
    logic [255:0] d_exp[$];
    mem_exp_t     mem_exp[$];

    logic         drv_rd[2];
    logic         drv_wr[2];
    logic [31:0]  drv_addr[2];
    logic [255:0] drv_wd[2];
    bit           ag_busy[2];
    int           issue_cyc[2];
    int           resp_cnt[2];
    cmd_t         ag_cmd[2];

    assign bus.i_read  = drv_rd[0];
    assign bus.i_write = drv_wr[0];
    assign bus.i_addr  = drv_addr[0];
    assign bus.i_wdata = drv_wd[0];
    assign bus.d_read  = drv_rd[1];
    assign bus.d_write = drv_wr[1];
    assign bus.d_addr  = drv_addr[1];
    assign bus.d_wdata = drv_wd[1];

    int mem_lat = 3;
    bit mem_stall = 1'b0;
    bit force_resp = 1'b0;

    function automatic logic [255:0] mdl(input logic [31:0] a);
        if (a == 32'h0000_1000) return {32{8'hAB}};
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic issue(input int a, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd, input bit pert);
        cmd_t c;
        c.write = wr; c.addr = addr; c.wdata = wd; c.perturb = pert;
        if (a == 0) begin i_q.push_back(c); i_exp.push_back(mdl(addr)); end
        else        begin d_q.push_back(c); d_exp.push_back(mdl(addr)); end
    endtask

    task automatic expect_mem(input logic [1:0] g, input logic [31:0] addr, input bit wr,
                              input logic [255:0] wd, input int lat);
        mem_exp_t e;
        e.grant = g; e.addr = addr; e.rd = !wr; e.wr = wr; e.wdata = wd; e.lat = lat;
        mem_exp.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((i_q.size() + d_q.size()) != 0 || ag_busy[0] || ag_busy[1] || bus.grant != 2'b00) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                fail_now("wait_idle");
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Cache agents: hold a request until its response, drop it the cycle after.
    initial begin : agents
        bit have;
        for (int a = 0; a < 2; a++) begin
            drv_rd[a] = 1'b0; drv_wr[a] = 1'b0; drv_addr[a] = '0; drv_wd[a] = '0;
            ag_busy[a] = 1'b0; issue_cyc[a] = 0;
        end
        forever begin
            int waited[2];
            int seen[2];
            @(posedge clk);
            #1;
            for (int a = 0; a < 2; a++) begin
                if (!rst_n) begin
                    drv_rd[a] = 1'b0; drv_wr[a] = 1'b0; ag_busy[a] = 1'b0;
                end else if (ag_busy[a]) begin
                    waited[a]++;
                    if (resp_cnt[a] != seen[a]) begin
                        drv_rd[a] = 1'b0; drv_wr[a] = 1'b0; ag_busy[a] = 1'b0;
                    end else if (waited[a] > 300) begin
                        fail_now(a == 0 ? "i_resp wait" : "d_resp wait");
                        drv_rd[a] = 1'b0; drv_wr[a] = 1'b0; ag_busy[a] = 1'b0;
                    end else if (ag_cmd[a].perturb) begin
                        drv_addr[a] = ~ag_cmd[a].addr;
                        drv_wd[a]   = ~ag_cmd[a].wdata;
                    end
                end else begin
                    have = 1'b0;
                    if (a == 0 && i_q.size() > 0) begin ag_cmd[a] = i_q.pop_front(); have = 1'b1; end
                    if (a == 1 && d_q.size() > 0) begin ag_cmd[a] = d_q.pop_front(); have = 1'b1; end
                    if (have) begin
                        drv_addr[a] = ag_cmd[a].addr;
                        drv_wd[a]   = ag_cmd[a].wdata;
                        drv_rd[a]   = !ag_cmd[a].write;
                        drv_wr[a]   = ag_cmd[a].write;
                        ag_busy[a]  = 1'b1;
                        waited[a]   = 0;
                        seen[a]     = resp_cnt[a];
                        issue_cyc[a] = cyc;
                    end
                end
            end
        end
    end

    // Memory responder: answers mem_lat cycles into a transaction unless stalled.
    initial begin : responder
        int  cnt;
        bit  done;
        cnt = 0; done = 1'b0;
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_resp = 1'b0; bus.mem_rdata = '0;
            if (force_resp) begin
                bus.mem_resp = 1'b1; bus.mem_rdata = {32{8'hEE}};
            end else if (!(bus.mem_read || bus.mem_write)) begin
                cnt = 0; done = 1'b0;
            end else if (!done && !mem_stall) begin
                if (cnt >= mem_lat) begin
                    bus.mem_resp = 1'b1; bus.mem_rdata = mdl(bus.mem_addr); done = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response or a new grant.
    initial begin : monitor
        mem_exp_t   cur;
        bit         have_cur;
        logic [1:0] prev_grant;
        int         idx;
        have_cur = 1'b0; prev_grant = 2'b00; resp_cnt[0] = 0; resp_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (bus.i_resp === 1'b1) begin
                resp_cnt[0]++;
                check("d_resp during i_resp", bus.d_resp, 0);
                check("d_rdata during i_resp", bus.d_rdata, 0);
                if (i_exp.size() == 0) fail_now("i_resp unexpected");
                else check("i_rdata", bus.i_rdata, i_exp.pop_front());
            end
            if (bus.d_resp === 1'b1) begin
                resp_cnt[1]++;
                check("i_resp during d_resp", bus.i_resp, 0);
                check("i_rdata during d_resp", bus.i_rdata, 0);
                if (d_exp.size() == 0) fail_now("d_resp unexpected");
                else check("d_rdata", bus.d_rdata, d_exp.pop_front());
            end
            if (bus.grant != 2'b00) begin
                if (prev_grant == 2'b00) begin
                    if (mem_exp.size() == 0) begin
                        fail_now("grant unexpected");
                        have_cur = 1'b0;
                    end else begin
                        cur = mem_exp.pop_front();
                        have_cur = 1'b1;
                        check("grant", bus.grant, cur.grant);
                        idx = (cur.grant == 2'b10) ? 1 : 0;
                        if (cur.lat >= 0) check("grant latency", 256'(cyc - issue_cyc[idx]), 256'(cur.lat));
                    end
                end
                if (have_cur) begin
                    check("mem_addr", bus.mem_addr, cur.addr);
                    check("mem_read", bus.mem_read, cur.rd);
                    check("mem_write", bus.mem_write, cur.wr);
                    check("mem_wdata", bus.mem_wdata, cur.wdata);
                end
            end else begin
                have_cur = 1'b0;
            end
            prev_grant = bus.grant;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        int n;
        repeat (3) @(negedge clk);
        check("reset grant", bus.grant, 2'b00);
        check("reset mem_read", bus.mem_read, 0);
        check("reset mem_write", bus.mem_write, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset timeout_err", bus.timeout_err, 0);
        check("reset i_resp", bus.i_resp, 0);
        check("reset d_resp", bus.d_resp, 0);
        rst_n = 1'b1;

        // Lone I read: granted the next cycle.
        expect_mem(2'b01, 32'h0000_1000, 1'b0, '0, 1);
        issue(0, 1'b0, 32'h0000_1000, '0, 1'b0);
        wait_idle();

        // Tie after I won last: D first, then I.
        expect_mem(2'b10, 32'h0000_3000, 1'b1, {8{32'hD1D1_0001}}, 1);
        expect_mem(2'b01, 32'h0000_2000, 1'b0, '0, -1);
        issue(0, 1'b0, 32'h0000_2000, '0, 1'b0);
        issue(1, 1'b1, 32'h0000_3000, {8{32'hD1D1_0001}}, 1'b0);
        wait_idle();

        // D alone, then a tie goes to I.
        expect_mem(2'b10, 32'h0000_3100, 1'b1, {8{32'hD1D1_0002}}, 1);
        issue(1, 1'b1, 32'h0000_3100, {8{32'hD1D1_0002}}, 1'b0);
        wait_idle();
        expect_mem(2'b01, 32'h0000_2100, 1'b0, '0, 1);
        expect_mem(2'b10, 32'h0000_3200, 1'b0, '0, -1);
        issue(0, 1'b0, 32'h0000_2100, '0, 1'b0);
        issue(1, 1'b0, 32'h0000_3200, '0, 1'b0);
        wait_idle();

        // I alone so that the next tie favours D.
        expect_mem(2'b01, 32'h0000_4000, 1'b0, '0, 1);
        issue(0, 1'b0, 32'h0000_4000, '0, 1'b0);
        wait_idle();

        // Continuous requests from both: D,I,D,I,D,I.
        for (int k = 0; k < 3; k++) begin
            expect_mem(2'b10, 32'h0000_6000 + 32'(k * 32) + 32'h3, 1'b1,
                       {8{32'hD000_0000 + 32'(k)}}, (k == 0) ? 1 : -1);
            expect_mem(2'b01, 32'h0000_5000 + 32'(k * 32) + 32'h1F, 1'b0, '0, -1);
        end
        for (int k = 0; k < 3; k++) begin
            issue(0, 1'b0, 32'h0000_5000 + 32'(k * 32) + 32'h1F, '0, 1'b0);
            issue(1, 1'b1, 32'h0000_6000 + 32'(k * 32) + 32'h3, {8{32'hD000_0000 + 32'(k)}}, 1'b0);
        end
        wait_idle();

        // D changes addr/wdata while being served; memory side must not follow.
        expect_mem(2'b10, 32'h0000_7000, 1'b1, {8{32'hCAFE_F00D}}, 1);
        issue(1, 1'b1, 32'h0000_7000, {8{32'hCAFE_F00D}}, 1'b1);
        wait_idle();

        // Watchdog: no response for a while, then completion.
        mem_stall = 1'b1;
        expect_mem(2'b10, 32'h0000_8000, 1'b0, '0, 1);
        issue(1, 1'b0, 32'h0000_8000, '0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant == 2'b00 && n < 50);
        if (bus.grant == 2'b00) fail_now("timeout test grant");
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("timeout_err serve cycle %0d", k), bus.timeout_err, (k >= 9) ? 1 : 0);
            @(negedge clk);
        end
        mem_stall = 1'b0;
        wait_idle();
        check("timeout_err sticky", bus.timeout_err, 1);

        // Reset in the middle of an I transaction.
        mem_stall = 1'b1;
        expect_mem(2'b01, 32'h0000_9000, 1'b0, '0, 1);
        issue(0, 1'b0, 32'h0000_9000, '0, 1'b0);
        repeat (4) @(negedge clk);
        check("grant before reset", bus.grant, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset grant", bus.grant, 2'b00);
        check("async reset mem_read", bus.mem_read, 0);
        check("async reset mem_addr", bus.mem_addr, 0);
        check("async reset timeout_err", bus.timeout_err, 0);
        i_exp.delete();
        mem_stall = 1'b0;
        force_resp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("i_resp during reset", bus.i_resp, 0);
            check("i_rdata during reset", bus.i_rdata, 0);
        end
        force_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation resumes after reset.
        expect_mem(2'b01, 32'h0000_1000, 1'b0, '0, 1);
        issue(0, 1'b0, 32'h0000_1000, '0, 1'b0);
        wait_idle();
        check("timeout_err after reset", bus.timeout_err, 0);

        check("mem_exp drained", 256'(mem_exp.size()), 0);
        check("i_exp drained", 256'(i_exp.size()), 0);
        check("d_exp drained", 256'(d_exp.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
